// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between a core request port, a word-wide
// data RAM (registered read) and a memory-mapped LED/switch word.
// Requests go through IDLE -> ACCESS -> (WAIT) -> RESP. RAM loads take the
// extra WAIT cycle for the registered RAM read.
// Optional feature: define SW_SYNC_EN to pass sw through a two-flop
// synchronizer before MMIO loads sample it. Without it, sw is sampled
// directly in ACCESS.
module lsu_ctrl #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] MMIO_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic [15:0]       sw,
    output logic [15:0]       led
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] led_q, led_d;

    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [15:0] sw_val;
    logic        is_ram, is_mmio, misaligned, illegal, req_err;

    // Select byte/half by offset, then sign- or zero-extend by funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

`ifdef SW_SYNC_EN
    logic [15:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;

    // Synchronizer shift: sw -> meta -> sync.
    always_comb begin
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign sw_val = sw_sync_q;
`else
    assign sw_val = sw;
`endif

    // Store data replicated so every enabled lane carries the right byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_wdata[8*gi +: 8] =
            (funct3_q[1:0] == 2'b00) ? wdata_q[7:0] :
            (funct3_q[1:0] == 2'b01) ? wdata_q[8*(gi%2) +: 8] :
                                       wdata_q[8*gi +: 8];
    end

    // Address decode, alignment/legality checks and byte-lane mask.
    always_comb begin
        is_ram  = (addr_q[31:RAM_AW+2] == '0);
        is_mmio = (addr_q[31:2] == MMIO_ADDR[31:2]);
        case (funct3_q)
            3'b001, 3'b101: misaligned = addr_q[0];
            3'b010:         misaligned = (addr_q[1:0] != 2'b00);
            default:        misaligned = 1'b0;
        endcase
        if (we_q)
            illegal = (funct3_q != 3'b000) && (funct3_q != 3'b001) && (funct3_q != 3'b010);
        else
            illegal = (funct3_q == 3'b011) || (funct3_q == 3'b110) || (funct3_q == 3'b111);
        req_err = misaligned || illegal || !(is_ram || is_mmio);
        case (funct3_q[1:0])
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // RAM strobes exist only in ACCESS for a valid RAM request.
    always_comb begin
        mem_en    = (state_q == ACCESS) && !req_err && is_ram;
        mem_we    = (mem_en && we_q) ? lane_mask : 4'b0000;
        mem_addr  = addr_q[RAM_AW+1:2];
        mem_wdata = lane_wdata;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign led        = led_q;

    // Next-state and datapath updates for the request FSM.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        led_d    = led_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (req_err) begin
                    err_d = 1'b1;
                end else if (is_ram) begin
                    if (!we_q)
                        state_d = WAIT;
                end else if (we_q) begin
                    if (lane_mask[0]) led_d[7:0]  = lane_wdata[7:0];
                    if (lane_mask[1]) led_d[15:8] = lane_wdata[15:8];
                end else begin
                    rdata_d = load_extract({16'h0, sw_val}, addr_q[1:0], funct3_q);
                end
            end
            WAIT: begin
                rdata_d = load_extract(mem_rdata, addr_q[1:0], funct3_q);
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            led_q    <= led_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed vector table, reset-in-WAIT sequence and
// randomized requests checked against a byte-level reference model.
module tb_lsu_ctrl;

    localparam int          RAM_AW    = 12;
    localparam int          RAM_BYTES = 4 * (1 << RAM_AW);
    localparam logic [31:0] MMIO      = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [RAM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [15:0]       sw, led;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    logic [31:0] ram [0:(1<<RAM_AW)-1];
    logic [7:0]  ref_mem [0:RAM_BYTES-1];
    logic [15:0] ref_led;

    lsu_ctrl #(.RAM_AW(RAM_AW), .MMIO_ADDR(MMIO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sw(sw), .led(led)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with byte lanes and registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    // Reference model: byte-addressed memory, size/legality rules, extension.
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, output bit e, output bit [31:0] rd,
                         output int lat, output int en, output bit [3:0] mwe);
        int  size, off;
        bit  legal, in_ram, in_mmio;
        bit [31:0] mmio_word;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off     = int'(a % 4);
        legal   = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        in_ram  = (a < RAM_BYTES);
        in_mmio = ((a & ~32'd3) == MMIO);
        e       = !legal || (int'(a % size) != 0) || !(in_ram || in_mmio);
        rd = 0; mwe = 0; en = 0; lat = 2;
        mmio_word = {16'h0, sw};
        if (!e) begin
            if (we) begin
                for (int i = 0; i < size; i++) begin
                    if (in_ram)
                        ref_mem[a + i] = wd[8*i +: 8];
                    else if (off + i == 0)
                        ref_led[7:0] = wd[8*i +: 8];
                    else if (off + i == 1)
                        ref_led[15:8] = wd[8*i +: 8];
                end
                if (in_ram) mwe = 4'(((1 << size) - 1) << off);
            end else begin
                for (int i = 0; i < size; i++)
                    rd[8*i +: 8] = in_ram ? ref_mem[a + i] : mmio_word[8*(off+i) +: 8];
                if (!f3[2] && size == 1 && rd[7])  rd = rd | 32'hFFFF_FF00;
                if (!f3[2] && size == 2 && rd[15]) rd = rd | 32'hFFFF_0000;
                if (in_ram) lat = 3;
            end
            if (in_ram) en = 1;
        end
    endtask

    // Issue one request and measure the response.
    task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, output bit got_err, output bit [31:0] got_rd,
                          output int got_lat, output int en_cnt, output bit [3:0] we_seen);
        int n;
        bit done;
        @(negedge clk);
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0; done = 0; en_cnt = 0; we_seen = 0; got_lat = -1; got_err = 0; got_rd = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_en) begin
                en_cnt++;
                we_seen = we_seen | mem_we;
            end
            if (resp_valid) begin
                done = 1; got_lat = n; got_err = resp_err; got_rd = resp_rdata;
            end
        end
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
        chk("ready_after_resp", {31'b0, req_ready}, 32'd1);
        txn_no++;
        $display("txn %0d we=%0d f3=%0d addr=%08h wdata=%08h rdata=%08h err=%0d lat=%0d led=%04h",
                 txn_no, we, f3, a, wd, got_rd, got_err, got_lat, led);
    endtask

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        err;
        bit [31:0] rdata;
        int        lat;
        bit [15:0] led;
        int        en;
        bit [3:0]  mwe;
    } vec_t;

    vec_t vecs [19];

    initial begin
        bit        g_err, m_err;
        bit [31:0] g_rd, m_rd;
        int        g_lat, m_lat, g_en, m_en;
        bit [3:0]  g_we, m_we;
        bit        we;
        bit [2:0]  f3;
        bit [31:0] a, wd;
        bit        seen;

        vecs[0]  = '{1'b1, 3'd2, 32'h0000_0010, 32'h0000_007B, 1'b0, 32'h0,         2, 16'h0000, 1, 4'hF};
        vecs[1]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_007B, 3, 16'h0000, 1, 4'h0};
        vecs[2]  = '{1'b1, 3'd1, 32'h0000_0012, 32'h0000_0214, 1'b0, 32'h0,         2, 16'h0000, 1, 4'hC};
        vecs[3]  = '{1'b0, 3'd1, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_0214, 3, 16'h0000, 1, 4'h0};
        vecs[4]  = '{1'b1, 3'd0, 32'h0000_0013, 32'h0000_0080, 1'b0, 32'h0,         2, 16'h0000, 1, 4'h8};
        vecs[5]  = '{1'b0, 3'd0, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FF80, 3, 16'h0000, 1, 4'h0};
        vecs[6]  = '{1'b0, 3'd4, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_0080, 3, 16'h0000, 1, 4'h0};
        vecs[7]  = '{1'b1, 3'd2, 32'h8000_0000, 32'hA5A5_1234, 1'b0, 32'h0,         2, 16'h1234, 0, 4'h0};
        vecs[8]  = '{1'b1, 3'd0, 32'h8000_0001, 32'h0000_00FF, 1'b0, 32'h0,         2, 16'hFF34, 0, 4'h0};
        vecs[9]  = '{1'b0, 3'd2, 32'h8000_0000, 32'h0,         1'b0, 32'h0000_00C3, 2, 16'hFF34, 0, 4'h0};
        vecs[10] = '{1'b0, 3'd1, 32'h8000_0002, 32'h0,         1'b0, 32'h0,         2, 16'hFF34, 0, 4'h0};
        vecs[11] = '{1'b0, 3'd2, 32'h0000_0002, 32'h0,         1'b1, 32'h0,         2, 16'hFF34, 0, 4'h0};
        vecs[12] = '{1'b1, 3'd1, 32'h0000_0011, 32'h0000_1234, 1'b1, 32'h0,         2, 16'hFF34, 0, 4'h0};
        vecs[13] = '{1'b0, 3'd2, 32'h4000_0000, 32'h0,         1'b1, 32'h0,         2, 16'hFF34, 0, 4'h0};
        vecs[14] = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,         1'b1, 32'h0,         2, 16'hFF34, 0, 4'h0};
        vecs[15] = '{1'b1, 3'd2, 32'h0000_3FFC, 32'hDEAD_BEEF, 1'b0, 32'h0,         2, 16'hFF34, 1, 4'hF};
        vecs[16] = '{1'b0, 3'd5, 32'h0000_3FFE, 32'h0,         1'b0, 32'h0000_DEAD, 3, 16'hFF34, 1, 4'h0};
        vecs[17] = '{1'b0, 3'd2, 32'h0000_4000, 32'h0,         1'b1, 32'h0,         2, 16'hFF34, 0, 4'h0};
        vecs[18] = '{1'b1, 3'd4, 32'h0000_0010, 32'h0000_00AA, 1'b1, 32'h0,         2, 16'hFF34, 0, 4'h0};

        for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = 32'h0;
        for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = 8'h0;
        ref_led = 16'h0;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; sw = 16'h00C3;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {{(32-RAM_AW){1'b0}}, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_led", {16'b0, led}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Directed vectors with hand-derived expectations.
        for (int i = 0; i < 19; i++) begin
            model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_err, m_rd, m_lat, m_en, m_we);
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, g_err, g_rd, g_lat, g_en, g_we);
            chk($sformatf("vec%0d_err", i),   {31'b0, g_err}, {31'b0, vecs[i].err});
            chk($sformatf("vec%0d_rdata", i), g_rd, vecs[i].rdata);
            chk($sformatf("vec%0d_lat", i),   g_lat, vecs[i].lat);
            chk($sformatf("vec%0d_led", i),   {16'b0, led}, {16'b0, vecs[i].led});
            chk($sformatf("vec%0d_mem_en", i), g_en, vecs[i].en);
            chk($sformatf("vec%0d_mem_we", i), {28'b0, g_we}, {28'b0, vecs[i].mwe});
        end

        // Randomized requests against the reference model.
        for (int t = 0; t < 200; t++) begin
            if (t % 8 == 0) begin
                sw = 16'($urandom);
                repeat (3) @(negedge clk);
            end
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0, 1, 2: a = $urandom_range(0, 63);
                3:       a = MMIO + $urandom_range(0, 3);
                4:       a = 32'h0000_3FF8 + $urandom_range(0, 7);
                default: a = $urandom_range(0, 1) ? 32'h0000_4000 + $urandom_range(0, 15) : $urandom;
            endcase
            wd = $urandom;
            model(we, f3, a, wd, m_err, m_rd, m_lat, m_en, m_we);
            do_req(we, f3, a, wd, g_err, g_rd, g_lat, g_en, g_we);
            chk("rnd_err",    {31'b0, g_err}, {31'b0, m_err});
            chk("rnd_rdata",  g_rd, m_rd);
            chk("rnd_lat",    g_lat, m_lat);
            chk("rnd_led",    {16'b0, led}, {16'b0, ref_led});
            chk("rnd_mem_en", g_en, m_en);
            chk("rnd_mem_we", {28'b0, g_we}, {28'b0, m_we});
        end

        // Make led nonzero, then reset while a RAM load sits in WAIT.
        model(1'b1, 3'd1, MMIO, 32'h0000_5A5A, m_err, m_rd, m_lat, m_en, m_we);
        do_req(1'b1, 3'd1, MMIO, 32'h0000_5A5A, g_err, g_rd, g_lat, g_en, g_we);
        chk("pre_rst_led", {16'b0, led}, 32'h0000_5A5A);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        @(negedge clk);
        if (resp_valid) seen = 1;
        rst = 1'b0;
        ref_led = 16'h0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_led", {16'b0, led}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (resp_valid) seen = 1;
            @(negedge clk);
        end
        chk("rst_no_resp", {31'b0, seen}, 32'd0);
        model(1'b0, 3'd2, 32'h10, 32'h0, m_err, m_rd, m_lat, m_en, m_we);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, g_err, g_rd, g_lat, g_en, g_we);
        chk("after_rst_err", {31'b0, g_err}, {31'b0, m_err});
        chk("after_rst_rdata", g_rd, m_rd);
        chk("after_rst_lat", g_lat, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
